// File: rtl/seq_det_pkg.sv
// Shared types, default sizes and the pattern-length clamp for the sequence
// detector controller and its match core.
package seq_det_pkg;

  localparam int DEF_WORD_W  = 8;
  localparam int DEF_PAT_MAX = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int LEN_W       = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // A pattern shorter than two bits would fire on nearly every bit, so two is the floor.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int pat_max);
    if (len < LEN_W'(2)) return LEN_W'(2);
    if (int'(len) > pat_max) return LEN_W'(pat_max);
    return len;
  endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Configuration, word handshake and detector status bundle between the bus
// side (master) and the sequence detector controller (slave).
interface seq_det_ctrl_if
  import seq_det_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int PAT_MAX = DEF_PAT_MAX,
  parameter int CNT_W   = DEF_CNT_W
) ();

  logic               cfg_we;
  logic [PAT_MAX-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_thresh;
  logic               in_valid;
  logic [WORD_W-1:0]  in_data;
  logic               in_ready;
  logic               busy;
  logic               bit_out;
  logic               bit_valid;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               irq;
  logic               irq_clr;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_thresh, in_valid, in_data, irq_clr,
    input  in_ready, busy, bit_out, bit_valid, match, match_count, irq
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_thresh, in_valid, in_data, irq_clr,
    output in_ready, busy, bit_out, bit_valid, match, match_count, irq
  );

endinterface

// File: rtl/seq_match_core.sv
// Bit-serial overlapping pattern matcher: keeps the recent bit history and a
// fill count, and registers a one-cycle match pulse.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_MAX = DEF_PAT_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit,
  output logic               match
);

  localparam int FILL_W = $clog2(PAT_MAX + 1);

  logic [PAT_MAX-1:0] hist;
  logic [PAT_MAX-1:0] hist_next;
  logic [PAT_MAX-1:0] mask;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_next;

  // The compare looks at the history as it will be once the current bit is in.
  always_comb begin
    hist_next = {hist[PAT_MAX-2:0], bit_in};
    fill_next = (int'(fill) == PAT_MAX) ? fill : fill + FILL_W'(1);
    mask      = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = bit_valid && (int'(fill_next) >= int'(len)) &&
          ((hist_next & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (clear) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (bit_valid) begin
        hist <= hist_next;
        fill <= fill_next;
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-level controller: accepts words over valid/ready, shifts them MSB-first
// into the match core, counts matches and raises a sticky threshold interrupt.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int PAT_MAX = DEF_PAT_MAX,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic           clk,
  input logic           reset,
  seq_det_ctrl_if.slave bus
);

  localparam int                BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t             state;
  logic [WORD_W-1:0]  shreg;
  logic [BIT_W-1:0]   bit_idx;
  logic [PAT_MAX-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [CNT_W-1:0]   thresh;
  logic [CNT_W-1:0]   count;
  logic               irq;
  logic               accept;
  logic               cfg_accept;
  logic               hit;

  assign accept     = bus.in_valid & bus.in_ready;
  assign cfg_accept = bus.cfg_we & (state == IDLE);

  assign bus.bit_out     = shreg[WORD_W-1];
  assign bus.match_count = count;
  assign bus.irq         = irq;

  // A word accepted on the last bit cycle reloads in place so bit_valid never drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_idx       <= '0;
      bus.in_ready  <= 1'b1;
      bus.busy      <= 1'b0;
      bus.bit_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= SHIFT;
            shreg         <= bus.in_data;
            bit_idx       <= LAST_BIT;
            bus.in_ready  <= (LAST_BIT == '0);
            bus.busy      <= 1'b1;
            bus.bit_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_idx == '0) begin
            if (accept) begin
              shreg        <= bus.in_data;
              bit_idx      <= LAST_BIT;
              bus.in_ready <= (LAST_BIT == '0);
            end else begin
              state         <= IDLE;
              shreg         <= '0;
              bus.in_ready  <= 1'b1;
              bus.busy      <= 1'b0;
              bus.bit_valid <= 1'b0;
            end
          end else begin
            shreg        <= shreg << 1;
            bit_idx      <= bit_idx - BIT_W'(1);
            bus.in_ready <= (bit_idx == BIT_W'(1));
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.busy      <= 1'b0;
          bus.bit_valid <= 1'b0;
        end
      endcase
    end
  end

  // irq_clr wins over a match landing on the same edge; that match goes uncounted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern <= '0;
      len     <= LEN_W'(2);
      thresh  <= '0;
      count   <= '0;
      irq     <= 1'b0;
    end else if (cfg_accept) begin
      pattern <= bus.cfg_pattern;
      len     <= clamp_len(bus.cfg_len, PAT_MAX);
      thresh  <= bus.cfg_thresh;
      count   <= '0;
      irq     <= 1'b0;
    end else if (bus.irq_clr) begin
      count <= '0;
      irq   <= 1'b0;
    end else if (hit && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
      if ((thresh != '0) && ((count + CNT_W'(1)) == thresh)) begin
        irq <= 1'b1;
      end
    end
  end

  seq_match_core #(
    .PAT_MAX (PAT_MAX)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .clear     (cfg_accept),
    .bit_in    (bus.bit_out),
    .bit_valid (bus.bit_valid),
    .pattern   (pattern),
    .len       (len),
    .hit       (hit),
    .match     (bus.match)
  );

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: a scoreboard of expected serial bits and
// match pulses plus hand-derived count/irq checks at chosen cycles.
module tb_seq_det_ctrl;
  import seq_det_pkg::*;

  logic clk;
  logic reset;

  seq_det_ctrl_if bus ();
  seq_det_ctrl_if #(.CNT_W(2)) bus_s ();

  seq_det_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seq_det_ctrl #(.CNT_W(2)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  assign bus_s.cfg_we      = bus.cfg_we;
  assign bus_s.cfg_pattern = bus.cfg_pattern;
  assign bus_s.cfg_len     = bus.cfg_len;
  assign bus_s.cfg_thresh  = bus.cfg_thresh[1:0];
  assign bus_s.in_valid    = bus.in_valid;
  assign bus_s.in_data     = bus.in_data;
  assign bus_s.irq_clr     = bus.irq_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic m;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] m_hist;
  logic [7:0] m_pat;
  int         m_fill;
  int         m_len;
  logic       exp_m = 1'b0;

  task automatic check_output(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", name, observed, expected);
    end
  endtask

  function automatic void model_cfg(input logic [7:0] pat, input int len);
    m_pat  = pat;
    m_len  = (len < 2) ? 2 : ((len > 8) ? 8 : len);
    m_hist = '0;
    m_fill = 0;
  endfunction

  // Queue the eight serial bits of a word and whether each one completes the pattern.
  function automatic void push_word(input logic [7:0] w);
    logic [8:0] one9;
    logic [7:0] mask;
    exp_t       e;
    one9 = 9'd1 << m_len;
    mask = 8'(one9 - 9'd1);
    for (int i = 7; i >= 0; i--) begin
      m_hist = {m_hist[6:0], w[i]};
      if (m_fill < 8) m_fill++;
      e.b = w[i];
      e.m = (m_fill >= m_len) && ((m_hist & mask) == (m_pat & mask));
      sb.push_back(e);
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      exp_m = 1'b0;
      sb.delete();
    end else begin
      check_output("match", bus.match, exp_m);
      exp_m = 1'b0;
      if (bus.bit_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check_output("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          check_output("bit_out", bus.bit_out, e.b);
          exp_m = e.m;
        end
      end
    end
  end

  task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len,
                           input logic [7:0] th, input bit takes_effect);
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_thresh  = th;
    if (takes_effect) model_cfg(pat, int'(len));
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic apply_word(input logic [7:0] w);
    int k;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bus.in_ready !== 1'b1) check_output("ready_timeout", 0, 1);
    push_word(w);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((bus.busy !== 1'b0 || sb.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check_output("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    bus.cfg_we      = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_thresh  = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.irq_clr     = 1'b0;
    model_cfg(8'h00, 2);
    repeat (2) @(negedge clk);

    check_output("rst_in_ready", bus.in_ready, 1);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_bit_out", bus.bit_out, 0);
    check_output("rst_bit_valid", bus.bit_valid, 0);
    check_output("rst_match", bus.match, 0);
    check_output("rst_count", bus.match_count, 0);
    check_output("rst_irq", bus.irq, 0);
    reset = 1'b0;
    @(negedge clk);

    // Pattern 1010 over 0xAA: matches after bits 4, 6 and 8.
    cfg_write(8'b1010, 4'd4, 8'd0, 1'b1);
    apply_word(8'hAA);
    wait_idle();
    check_output("single_word_count", bus.match_count, 3);

    // Second word offered during the first word's last bit; 16 contiguous bits.
    cfg_write(8'b1010, 4'd4, 8'd0, 1'b1);
    apply_word(8'hAA);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    for (int k = 1; k <= 16; k++) begin
      check_output("bv_run", bus.bit_valid, 1);
      if (k == 8) begin
        check_output("ready_last_bit", bus.in_ready, 1);
        push_word(8'hAA);
      end
      @(negedge clk);
      if (k == 8) bus.in_valid = 1'b0;
    end
    check_output("bv_end", bus.bit_valid, 0);
    wait_idle();
    check_output("b2b_count", bus.match_count, 7);

    // Pattern 11, threshold 2: irq rises with the second match (cycle 4).
    cfg_write(8'b11, 4'd2, 8'd2, 1'b1);
    apply_word(8'hFF);
    repeat (2) @(negedge clk);
    check_output("pre_irq_count", bus.match_count, 1);
    check_output("pre_irq", bus.irq, 0);
    @(negedge clk);
    check_output("irq_count", bus.match_count, 2);
    check_output("irq_rise", bus.irq, 1);
    check_output("s_irq_rise", bus_s.irq, 1);
    wait_idle();
    check_output("ff_count", bus.match_count, 7);
    check_output("ff_irq", bus.irq, 1);
    check_output("s_sat_count", bus_s.match_count, 3);
    check_output("s_sat_irq", bus_s.irq, 1);

    // irq_clr during the bit that completes the last match: that match is dropped.
    cfg_write(8'b11, 4'd2, 8'd2, 1'b1);
    apply_word(8'hFF);
    repeat (7) @(negedge clk);
    check_output("pre_clr_count", bus.match_count, 6);
    check_output("pre_clr_irq", bus.irq, 1);
    check_output("s_pre_clr_count", bus_s.match_count, 3);
    bus.irq_clr = 1'b1;
    @(negedge clk);
    bus.irq_clr = 1'b0;
    check_output("clr_count", bus.match_count, 0);
    check_output("clr_irq", bus.irq, 0);
    check_output("s_clr_count", bus_s.match_count, 0);
    check_output("s_clr_irq", bus_s.irq, 0);
    wait_idle();
    check_output("post_clr_count", bus.match_count, 0);

    // Config write while shifting must be ignored.
    cfg_write(8'b1010, 4'd4, 8'd0, 1'b1);
    apply_word(8'hAA);
    @(negedge clk);
    cfg_write(8'b11, 4'd2, 8'd5, 1'b0);
    wait_idle();
    check_output("busy_cfg_count", bus.match_count, 3);
    check_output("busy_cfg_irq", bus.irq, 0);

    // len=1 clamps to 2: pattern 11 over 0xF0 gives 3 matches, not 4.
    cfg_write(8'b11, 4'd1, 8'd0, 1'b1);
    apply_word(8'hF0);
    wait_idle();
    check_output("clamp_count", bus.match_count, 3);

    // Reset while bit index 3 of 0xAA is on bit_out (one match already counted).
    cfg_write(8'b1010, 4'd4, 8'd0, 1'b1);
    apply_word(8'hAA);
    repeat (4) @(negedge clk);
    check_output("pre_rst_count", bus.match_count, 1);
    #2 reset = 1'b1;
    model_cfg(8'h00, 2);
    @(negedge clk);
    check_output("mid_rst_busy", bus.busy, 0);
    check_output("mid_rst_ready", bus.in_ready, 1);
    check_output("mid_rst_count", bus.match_count, 0);
    check_output("mid_rst_bv", bus.bit_valid, 0);
    #2 reset = 1'b0;
    @(negedge clk);
    apply_word(8'h7F);
    wait_idle();
    check_output("post_rst_count", bus.match_count, 0);

    // Threshold 0 never interrupts; 7 + 8 + 5 matches across three words.
    cfg_write(8'b11, 4'd2, 8'd0, 1'b1);
    apply_word(8'hFF);
    wait_idle();
    apply_word(8'hFF);
    wait_idle();
    apply_word(8'hF8);
    wait_idle();
    check_output("t0_count", bus.match_count, 20);
    check_output("t0_irq", bus.irq, 0);
    check_output("s_t0_count", bus_s.match_count, 3);
    check_output("s_t0_irq", bus_s.irq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Word-level controller for the team's serial sequence detector. It accepts parallel words over a valid/ready handshake and serializes them MSB-first into a programmable overlapping pattern matcher, one bit per cycle. It counts matches and raises a sticky interrupt at a programmed threshold. It sits between the bus-side data source and the bit-serial detection logic, sequencing the detector so software never drives `x` directly.

## Interface
- `WORD_W`, 8: input word width; bits shifted per word.
- `PAT_MAX`, 8: maximum pattern length and history depth.
- `CNT_W`, 8: match counter width.

- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `cfg_we` input 1: configuration write strobe.
- `cfg_pattern` input PAT_MAX: pattern. `cfg_pattern[len-1]` is the first bit expected and `cfg_pattern[0]` is the last.
- `cfg_len` input 4: pattern length. Values below 2 are clamped to 2; values above PAT_MAX are clamped to PAT_MAX.
- `cfg_thresh` input CNT_W: interrupt threshold; 0 disables the interrupt.
- `in_valid` input 1: input word valid.
- `in_data` input WORD_W: input word.
- `in_ready` output 1: controller can accept a word.
- `busy` output 1: shifting in progress.
- `bit_out` output 1: current serial bit.
- `bit_valid` output 1: `bit_out` is meaningful this cycle.
- `match` output 1: one-cycle pulse on a pattern match.
- `match_count` output CNT_W: saturating match count.
- `irq` output 1: sticky threshold interrupt.
- `irq_clr` input 1: clears `irq` and `match_count`.

## Operation
- The FSM has two states.
  - IDLE: `in_ready`=1.
  - SHIFT: runs for WORD_W cycles, indexed by a bit counter from WORD_W-1 down to 0.
- IDLE→SHIFT on `in_valid & in_ready`. The word is latched into a shift register.
- In SHIFT, `in_ready`=1 only in the last bit cycle (index 0). An accept there reloads the register and stays in SHIFT, giving 100% throughput. With no accept, the FSM returns to IDLE.
- `bit_out` is the shift register MSB; `bit_valid`=1 in SHIFT.
- Each valid bit is shifted into a PAT_MAX-bit history register, and a fill count saturates at PAT_MAX.
- Match condition: fill ≥ len (including the current bit) and the last len bits equal `cfg_pattern[len-1:0]`. Matches overlap, and history persists across words.
- Config:
  - `cfg_we` is accepted only in IDLE and ignored while busy.
  - An accepted write latches pattern, len and thresh, and clears history, fill count, `match_count` and `irq`.
- Counter:
  - Increments on each match and saturates at 2^CNT_W-1.
  - `irq` sets on the cycle the count becomes equal to a nonzero thresh, and stays set until `irq_clr` or config write.
- `irq_clr` has priority over a coincident match: count→0, `irq`→0, and that match is not counted. The `match` pulse itself still appears.
- Reset values:
  - Outputs: `in_ready`=1, `busy`=0, `bit_out`=0, `bit_valid`=0, `match`=0, `match_count`=0, `irq`=0.
  - Internal: FSM IDLE, history and fill 0.
  - Config registers: pattern 0, len 2, thresh 0.
- Reset mid-SHIFT abandons the word immediately; no further bits or matches occur.

## Timing
- Accept at edge T: bit WORD_W-1 appears on `bit_out` in the cycle after T, and bit 0 appears WORD_W cycles after T.
- `match` is registered: it pulses in the cycle after the bit that completes the pattern.
- `match_count` and `irq` update on the same edge as `match` rises.
- `busy` = (state==SHIFT).
- Back-to-back accepts produce no gap in `bit_valid`.

## Structure
- Shared package `seq_det_pkg` holds:
  - the state enum (IDLE, SHIFT);
  - default constants WORD_W, PAT_MAX, CNT_W;
  - the len clamp function.
- Sub-module `seq_match_core` holds the history register, fill count, compare and registered `match`. It is driven by `bit_out`/`bit_valid`, plus a clear from the controller.
- The controller holds the FSM, shift register, bit counter, config registers, counter and irq.

## Test plan
- Pattern 1010, len 4, single word 0xAA → 3 `match` pulses (after bits 4, 6, 8); `match_count`=3.
- Same config, two back-to-back 0xAA words (second accepted in the last bit cycle) → `bit_valid` continuous for 16 cycles; 7 matches total (cross-word match at second word bit 2).
- thresh=2, pattern 11 len 2, word 0xFF → `irq` rises with the 2nd match; count saturates correctly with CNT_W=2 after 3; `irq_clr` coincident with a match → count 0, `irq` 0.
- `cfg_we` during SHIFT → ignored: pattern unchanged, count unchanged. `cfg_we` in IDLE with len=1 → clamped to 2.
- Assert `reset` at bit 3 of a shifting word → next cycle `busy`=0, `in_ready`=1, `match_count`=0, no `match` pulses. A new word then shifts cleanly with empty history.
- thresh=0, 20 matches → `irq` never asserts; `match_count`=20.
